// File: rtl/ms_countdown_timer.sv
// ms_countdown_timer: per-turn millisecond countdown for the sequence-matching game.
// A 16-bit LFSR prescaler produces one tick per ms while running. Each tick
// decrements Remaining and increments Elapsed. Reaching zero by counting
// raises Timeout for one cycle and latches Expired.
module ms_countdown_timer #(
  parameter int unsigned TW       = 21,
  parameter logic [15:0] SEED     = 16'hFFFF,
  parameter logic [15:0] TERMINAL = 16'h6DB6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Load,
  input  logic [TW-1:0] LoadVal,
  input  logic          Run,
  output logic [TW-1:0] Remaining,
  output logic [TW-1:0] Elapsed,
  output logic          Tick,
  output logic          Timeout,
  output logic          Expired,
  output logic          Busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic        fb;

  // Next prescaler state for a single shift.
  always_comb begin
    fb        = lfsr[15];
    lfsr_step = {lfsr[14:5], lfsr[4] ^ fb, lfsr[3], lfsr[2] ^ fb, lfsr[1] ^ fb, lfsr[0], fb};
  end

  // Control FSM, prescaler and registered outputs.
  // Busy/Expired are written alongside each state change so that they always
  // reflect the state being entered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      Remaining <= '0;
      Elapsed   <= '0;
      Tick      <= 1'b0;
      Timeout   <= 1'b0;
      Expired   <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Tick    <= 1'b0;
      Timeout <= 1'b0;
      if (Load) begin
        Remaining <= LoadVal;
        Elapsed   <= '0;
        lfsr      <= SEED;
        Busy      <= 1'b0;
        if (LoadVal != '0) begin
          state   <= IDLE;
          Expired <= 1'b0;
        end else begin
          state   <= EXPIRED;
          Expired <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (Run && (Remaining != '0)) begin
              state <= RUN;
              Busy  <= 1'b1;
            end
          end
          RUN: begin
            // The prescaler is enabled by the current state, so the tick or
            // shift is taken even on the edge where Run drops.
            if (lfsr == TERMINAL) begin
              lfsr      <= SEED;
              Tick      <= 1'b1;
              Remaining <= Remaining - 1'b1;
              if (Elapsed != '1) begin
                Elapsed <= Elapsed + 1'b1;
              end
              if (Remaining == TW'(1)) begin
                Timeout <= 1'b1;
                Expired <= 1'b1;
                Busy    <= 1'b0;
                state   <= EXPIRED;
              end else if (!Run) begin
                state <= PAUSE;
              end
            end else begin
              lfsr <= lfsr_step;
              if (!Run) begin
                state <= PAUSE;
              end
            end
          end
          PAUSE: begin
            if (Run) begin
              state <= RUN;
            end
          end
          EXPIRED: begin
            state <= EXPIRED;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Self-checking bench for ms_countdown_timer.
module tb_ms_countdown_timer;

  localparam int unsigned TW = 21;

  logic          Clk;
  logic          Rst;
  logic          Load;
  logic [TW-1:0] LoadVal;
  logic          Run;
  logic [TW-1:0] Remaining;
  logic [TW-1:0] Elapsed;
  logic          Tick;
  logic          Timeout;
  logic          Expired;
  logic          Busy;

  logic          Load2;
  logic [TW-1:0] LoadVal2;
  logic          Run2;
  logic [TW-1:0] Remaining2;
  logic [TW-1:0] Elapsed2;
  logic          Tick2;
  logic          Timeout2;
  logic          Expired2;
  logic          Busy2;

  int n_vec;
  int n_bad;

  ms_countdown_timer #(
    .TW       (TW),
    .SEED     (16'hFFFF),
    .TERMINAL (16'hFFD3)
  ) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Load      (Load),
    .LoadVal   (LoadVal),
    .Run       (Run),
    .Remaining (Remaining),
    .Elapsed   (Elapsed),
    .Tick      (Tick),
    .Timeout   (Timeout),
    .Expired   (Expired),
    .Busy      (Busy)
  );

  ms_countdown_timer u_def (
    .Clk       (Clk),
    .Rst       (Rst),
    .Load      (Load2),
    .LoadVal   (LoadVal2),
    .Run       (Run2),
    .Remaining (Remaining2),
    .Elapsed   (Elapsed2),
    .Tick      (Tick2),
    .Timeout   (Timeout2),
    .Expired   (Expired2),
    .Busy      (Busy2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          ld;
    logic [TW-1:0] lv;
    logic          run;
    logic [TW-1:0] rem;
    logic [TW-1:0] el;
    logic          tk;
    logic          to;
    logic          ex;
    logic          bz;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input int lv, input logic run,
                     input int rem, input int el,
                     input logic tk, input logic to, input logic ex, input logic bz);
    vec_t v;
    v.ld  = ld;
    v.lv  = TW'(lv);
    v.run = run;
    v.rem = TW'(rem);
    v.el  = TW'(el);
    v.tk  = tk;
    v.to  = to;
    v.ex  = ex;
    v.bz  = bz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] o);
    logic f;
    f = o[15];
    return {o[14:5], o[4] ^ f, o[3], o[2] ^ f, o[1] ^ f, o[0], f};
  endfunction

  initial begin
    logic [15:0] s;
    int          p;
    int          t1;
    int          t2;
    int          to1;
    int          to2;

    n_vec    = 0;
    n_bad    = 0;
    Rst      = 1'b1;
    Load     = 1'b0;
    LoadVal  = '0;
    Run      = 1'b0;
    Load2    = 1'b0;
    LoadVal2 = '0;
    Run2     = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Reset mid-count: Load 5, run a few cycles, then assert Rst between edges.
    Load = 1'b1; LoadVal = TW'(5);
    @(negedge Clk);
    Load = 1'b0; Run = 1'b1;
    repeat (4) @(negedge Clk);
    chk("pre_rst_rem", Remaining, 4);
    #2 Rst = 1'b1;
    #1;
    chk("rst_rem", Remaining, 0);
    chk("rst_el", Elapsed, 0);
    chk("rst_flags", {Tick, Timeout, Expired, Busy}, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    chk("idle_run_busy", Busy, 0);
    chk("idle_run_rem", Remaining, 0);
    chk("idle_run_tick", Tick, 0);
    Run = 1'b0;

    // Load 3, Run held to expiry.
    add(1, 3, 0, 3, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 2, 1, 1, 0, 0, 1);
    add(0, 0, 1, 2, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 2, 1, 0, 0, 1);
    add(0, 0, 1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 1, 1, 1, 0);
    add(0, 0, 1, 0, 3, 0, 0, 1, 0);
    add(0, 0, 1, 0, 3, 0, 0, 1, 0);
    // Load 4, one enabled cycle, six-cycle pause, resume.
    add(1, 4, 0, 4, 0, 0, 0, 0, 0);
    add(0, 0, 1, 4, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4, 0, 0, 0, 0, 1);
    add(0, 0, 1, 3, 1, 1, 0, 0, 1);
    // Load on the terminal-count edge wins over the tick.
    add(1, 3, 0, 3, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 2, 1, 1, 0, 0, 1);
    add(0, 0, 1, 2, 1, 0, 0, 0, 1);
    add(1, 7, 1, 7, 0, 0, 0, 0, 0);
    add(0, 0, 1, 7, 0, 0, 0, 0, 1);
    add(0, 0, 1, 7, 0, 0, 0, 0, 1);
    add(0, 0, 1, 6, 1, 1, 0, 0, 1);
    // Run dropped on a tick edge: tick taken, then paused.
    add(0, 0, 1, 6, 1, 0, 0, 0, 1);
    add(0, 0, 0, 5, 2, 1, 0, 0, 1);
    add(0, 0, 0, 5, 2, 0, 0, 0, 1);
    add(0, 0, 1, 5, 2, 0, 0, 0, 1);
    add(0, 0, 1, 5, 2, 0, 0, 0, 1);
    add(0, 0, 1, 4, 3, 1, 0, 0, 1);
    // Load 0 expires without Timeout; then Load 1 times out after one period.
    add(1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      Load    = tbl[i].ld;
      LoadVal = tbl[i].lv;
      Run     = tbl[i].run;
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("v%0d_rem", i), Remaining, tbl[i].rem);
      chk($sformatf("v%0d_el", i), Elapsed, tbl[i].el);
      chk($sformatf("v%0d_flags(tick,to,exp,busy)", i),
          {Tick, Timeout, Expired, Busy}, {tbl[i].tk, tbl[i].to, tbl[i].ex, tbl[i].bz});
    end
    Load = 1'b0;
    Run  = 1'b0;

    // Default prescaler: period from the LFSR model, Load 2, two ticks.
    s = 16'hFFFF;
    p = 0;
    while (s != 16'h6DB6 && p < 70000) begin
      s = lstep(s);
      p++;
    end
    p = p + 1;
    Load2 = 1'b1; LoadVal2 = TW'(2);
    @(negedge Clk);
    Load2 = 1'b0; Run2 = 1'b1;
    t1 = -1; t2 = -1; to1 = 0; to2 = 0;
    for (int c = 1; c <= 2 * p + 20 && t2 < 0; c++) begin
      @(negedge Clk);
      if (Tick2) begin
        if (t1 < 0) begin
          t1 = c;
          to1 = int'(Timeout2);
        end else begin
          t2 = c;
          to2 = int'(Timeout2);
        end
      end
    end
    chk("def_first_tick_cycle", t1, p + 1);
    chk("def_tick_spacing", t2 - t1, p);
    chk("def_timeout_on_1st", to1, 0);
    chk("def_timeout_on_2nd", to2, 1);
    @(negedge Clk);
    chk("def_expired", {Expired2, Busy2}, 2'b10);
    chk("def_rem_el", {Remaining2, Elapsed2}, {TW'(0), TW'(2)});
    Run2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
